// File: rtl/gshare_btb_predictor_if.sv
// Fetch-lookup and EX-training bundle between the pipeline and the branch predictor.
// The pipeline drives lookups and training through master; the predictor answers through slave.
interface gshare_btb_predictor_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int GHR_BITS   = 6
);
  logic [ADDR_WIDTH-1:0] pc_if;
  logic                  je;
  logic [ADDR_WIDTH-1:0] jdest;
  logic [GHR_BITS-1:0]   pred_ghr;
  logic                  upd_valid;
  logic [ADDR_WIDTH-1:0] pc_ex;
  logic [1:0]            kind_ex;
  logic                  jmp_res;
  logic [ADDR_WIDTH-1:0] dest;
  logic [GHR_BITS-1:0]   ghr_ex;

  modport master (
    output pc_if, upd_valid, pc_ex, kind_ex, jmp_res, dest, ghr_ex,
    input  je, jdest, pred_ghr
  );

  modport slave (
    input  pc_if, upd_valid, pc_ex, kind_ex, jmp_res, dest, ghr_ex,
    output je, jdest, pred_ghr
  );
endinterface

// File: rtl/gshare_btb_predictor.sv
// IF-stage branch predictor: tagged BTB, gshare PHT and return-address stack.
// Lookup is combinational from pc_if; all training is non-speculative from EX.
module gshare_btb_predictor #(
  parameter int ADDR_WIDTH = 32,
  parameter int INDEX_BITS = 6,
  parameter int GHR_BITS   = 6,
  parameter int CNT_BITS   = 2,
  parameter int RAS_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  gshare_btb_predictor_if.slave bus
);
  localparam int N_ENT = 1 << INDEX_BITS;
  localparam int TAG_W = ADDR_WIDTH - INDEX_BITS - 2;
  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int RCNT_W = $clog2(RAS_DEPTH + 1);
  localparam logic [CNT_BITS-1:0] CNT_MAX  = '1;
  localparam logic [CNT_BITS-1:0] CNT_INIT = {1'b1, {(CNT_BITS-1){1'b0}}};
  localparam logic [1:0] K_COND = 2'b00;
  localparam logic [1:0] K_RET  = 2'b10;
  localparam logic [1:0] K_CALL = 2'b11;

  logic                  btb_valid  [N_ENT];
  logic [TAG_W-1:0]      btb_tag    [N_ENT];
  logic [ADDR_WIDTH-1:0] btb_target [N_ENT];
  logic [1:0]            btb_kind   [N_ENT];
  logic [CNT_BITS-1:0]   pht        [N_ENT];
  logic [ADDR_WIDTH-1:0] ras        [RAS_DEPTH];
  logic [GHR_BITS-1:0]   ghr;
  logic [PTR_W-1:0]      ras_top;
  logic [RCNT_W-1:0]     ras_cnt;

  logic [INDEX_BITS-1:0] idx_if, pidx_if, idx_ex, pidx_ex;
  logic [TAG_W-1:0]      tag_if, tag_ex;
  logic [PTR_W-1:0]      top_inc, top_dec;
  logic [CNT_BITS-1:0]   cnt_cur, cnt_next;
  logic                  hit, upd, push, pop;
  logic                  unused_pc_bits;

  assign idx_if  = bus.pc_if[INDEX_BITS+1:2];
  assign tag_if  = bus.pc_if[ADDR_WIDTH-1:INDEX_BITS+2];
  assign pidx_if = idx_if ^ INDEX_BITS'(ghr);
  assign idx_ex  = bus.pc_ex[INDEX_BITS+1:2];
  assign tag_ex  = bus.pc_ex[ADDR_WIDTH-1:INDEX_BITS+2];
  assign pidx_ex = idx_ex ^ INDEX_BITS'(bus.ghr_ex);
  assign unused_pc_bits = ^bus.pc_if[1:0];

  always_comb begin
    hit       = btb_valid[idx_if] && (btb_tag[idx_if] == tag_if);
    bus.je    = hit && ((btb_kind[idx_if] != K_COND) || pht[pidx_if][CNT_BITS-1]);
    bus.jdest = '0;
    if (bus.je) begin
      if (btb_kind[idx_if] == K_RET && ras_cnt != '0) bus.jdest = ras[ras_top];
      else                                             bus.jdest = btb_target[idx_if];
    end
  end

  assign bus.pred_ghr = ghr;

  // rst_n gates the data-path writes so an update landing during reset leaves no trace
  assign upd  = bus.upd_valid && rst_n;
  assign push = upd && bus.jmp_res && (bus.kind_ex == K_CALL);
  assign pop  = upd && bus.jmp_res && (bus.kind_ex == K_RET);

  assign top_inc = (ras_top == PTR_W'(RAS_DEPTH - 1)) ? '0 : ras_top + 1'b1;
  assign top_dec = (ras_top == '0) ? PTR_W'(RAS_DEPTH - 1) : ras_top - 1'b1;

  always_comb begin
    cnt_cur  = pht[pidx_ex];
    cnt_next = cnt_cur;
    if (bus.jmp_res) begin
      if (cnt_cur != CNT_MAX) cnt_next = cnt_cur + 1'b1;
    end else begin
      if (cnt_cur != '0) cnt_next = cnt_cur - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_ENT; i++) begin
        btb_valid[i] <= 1'b0;
        pht[i]       <= CNT_INIT;
      end
      ghr     <= '0;
      ras_top <= '0;
      ras_cnt <= '0;
    end else if (bus.upd_valid) begin
      if (bus.jmp_res) btb_valid[idx_ex] <= 1'b1;
      if (bus.kind_ex == K_COND) begin
        pht[pidx_ex] <= cnt_next;
        ghr          <= GHR_BITS'({ghr, bus.jmp_res});
      end
      // a full stack overwrites its oldest slot, so the count saturates
      if (push) begin
        ras_top <= top_inc;
        if (ras_cnt != RCNT_W'(RAS_DEPTH)) ras_cnt <= ras_cnt + 1'b1;
      end else if (pop && ras_cnt != '0) begin
        ras_top <= top_dec;
        ras_cnt <= ras_cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (upd && bus.jmp_res) begin
      btb_tag[idx_ex]    <= tag_ex;
      btb_target[idx_ex] <= bus.dest;
      btb_kind[idx_ex]   <= bus.kind_ex;
    end
    if (push) ras[top_inc] <= bus.pc_ex + ADDR_WIDTH'(4);
  end
endmodule

// File: tb/tb_gshare_btb_predictor.sv
// Directed vector bench for gshare_btb_predictor: lookup/training table plus an async reset sequence.
module tb_gshare_btb_predictor;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  gshare_btb_predictor_if #(.ADDR_WIDTH(32), .GHR_BITS(6)) bus ();

  gshare_btb_predictor #(
    .ADDR_WIDTH(32), .INDEX_BITS(6), .GHR_BITS(6), .CNT_BITS(2), .RAS_DEPTH(4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        uv;
    logic [31:0] pc_ex;
    logic [1:0]  kind;
    logic        res;
    logic [31:0] dest;
    logic [5:0]  gx;
    logic [31:0] pc_if;
    logic        je;
    logic [31:0] jd;
    logic [5:0]  g;
  } vec_t;

  vec_t vecs[$];
  vec_t post[$];

  function automatic vec_t v(logic uv, logic [31:0] pce, logic [1:0] k, logic r,
                             logic [31:0] d, logic [5:0] gx, logic [31:0] pci,
                             logic je, logic [31:0] jd, logic [5:0] g);
    vec_t t;
    t.uv = uv; t.pc_ex = pce; t.kind = k; t.res = r; t.dest = d; t.gx = gx;
    t.pc_if = pci; t.je = je; t.jd = jd; t.g = g;
    return t;
  endfunction

  task automatic chk(string name, int row, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  task automatic drive(vec_t t);
    bus.upd_valid = t.uv;
    bus.pc_ex     = t.pc_ex;
    bus.kind_ex   = t.kind;
    bus.jmp_res   = t.res;
    bus.dest      = t.dest;
    bus.ghr_ex    = t.gx;
    bus.pc_if     = t.pc_if;
  endtask

  // outputs reflect state before this row's update edge
  task automatic run_vec(vec_t t, int row);
    @(negedge clk);
    drive(t);
    #1;
    chk("je", row, 32'(bus.je), 32'(t.je));
    chk("jdest", row, bus.jdest, t.jd);
    chk("pred_ghr", row, 32'(bus.pred_ghr), 32'(t.g));
  endtask

  initial begin
    //               uv pc_ex     k  r dest      gx  pc_if     je jdest     ghr
    vecs.push_back(v(0, 32'h0,    0, 0, 32'h0,    0, 32'h100,  0, 32'h0,    0));
    vecs.push_back(v(1, 32'h100,  0, 1, 32'h200,  0, 32'h100,  0, 32'h0,    0));
    vecs.push_back(v(1, 32'h100,  0, 1, 32'h200, 14, 32'h100,  1, 32'h200,  1));
    vecs.push_back(v(1, 32'h100,  0, 1, 32'h200, 14, 32'h1100, 0, 32'h0,    3));
    vecs.push_back(v(1, 32'h100,  0, 0, 32'h0,   14, 32'h100,  1, 32'h200,  7));
    vecs.push_back(v(1, 32'h100,  0, 0, 32'h0,   48, 32'h100,  1, 32'h200, 14));
    vecs.push_back(v(1, 32'h100,  0, 0, 32'h0,   48, 32'h100,  1, 32'h200, 28));
    vecs.push_back(v(1, 32'h100,  0, 0, 32'h0,   48, 32'h100,  1, 32'h200, 56));
    vecs.push_back(v(0, 32'h0,    0, 0, 32'h0,    0, 32'h100,  0, 32'h0,   48));
    vecs.push_back(v(0, 32'h0,    0, 0, 32'h0,    0, 32'h1100, 0, 32'h0,   48));
    vecs.push_back(v(1, 32'h500,  2, 1, 32'h999,  0, 32'h500,  0, 32'h0,   48));
    vecs.push_back(v(1, 32'h304,  3, 1, 32'h3000, 0, 32'h500,  1, 32'h999, 48));
    vecs.push_back(v(0, 32'h0,    0, 0, 32'h0,    0, 32'h500,  1, 32'h308, 48));
    vecs.push_back(v(1, 32'h500,  2, 1, 32'h999,  0, 32'h500,  1, 32'h308, 48));
    vecs.push_back(v(0, 32'h0,    0, 0, 32'h0,    0, 32'h500,  1, 32'h999, 48));
    vecs.push_back(v(1, 32'h10,   3, 1, 32'h1000, 0, 32'h500,  1, 32'h999, 48));
    vecs.push_back(v(1, 32'h20,   3, 1, 32'h1000, 0, 32'h500,  1, 32'h14,  48));
    vecs.push_back(v(1, 32'h30,   3, 1, 32'h1000, 0, 32'h500,  1, 32'h24,  48));
    vecs.push_back(v(1, 32'h40,   3, 1, 32'h1000, 0, 32'h500,  1, 32'h34,  48));
    vecs.push_back(v(1, 32'h50,   3, 1, 32'h1000, 0, 32'h500,  1, 32'h44,  48));
    vecs.push_back(v(1, 32'h500,  2, 1, 32'h999,  0, 32'h500,  1, 32'h54,  48));
    vecs.push_back(v(1, 32'h500,  2, 1, 32'h999,  0, 32'h500,  1, 32'h44,  48));
    vecs.push_back(v(1, 32'h500,  2, 1, 32'h999,  0, 32'h500,  1, 32'h34,  48));
    vecs.push_back(v(1, 32'h500,  2, 1, 32'h999,  0, 32'h500,  1, 32'h24,  48));
    vecs.push_back(v(0, 32'h0,    0, 0, 32'h0,    0, 32'h500,  1, 32'h999, 48));
    vecs.push_back(v(0, 32'h0,    0, 0, 32'h0,    0, 32'h50,   1, 32'h1000,48));
    vecs.push_back(v(1, 32'h80,   1, 1, 32'h2000, 0, 32'h80,   0, 32'h0,   48));
    vecs.push_back(v(1, 32'hC0,   1, 0, 32'h2400, 0, 32'h80,   1, 32'h2000,48));
    vecs.push_back(v(0, 32'h100,  0, 1, 32'h200,  0, 32'hC0,   0, 32'h0,   48));
    vecs.push_back(v(0, 32'h0,    0, 0, 32'h0,    0, 32'h100,  0, 32'h0,   48));

    post.push_back(v(0, 32'h0,    0, 0, 32'h0,    0, 32'h80,   0, 32'h0,    0));
    post.push_back(v(0, 32'h0,    0, 0, 32'h0,    0, 32'h140,  0, 32'h0,    0));
    post.push_back(v(0, 32'h0,    0, 0, 32'h0,    0, 32'h50,   0, 32'h0,    0));
    post.push_back(v(1, 32'h100,  0, 1, 32'h200,  0, 32'h500,  0, 32'h0,    0));
    post.push_back(v(0, 32'h0,    0, 0, 32'h0,    0, 32'h100,  1, 32'h200,  1));
    post.push_back(v(0, 32'h0,    0, 0, 32'h0,    0, 32'h500,  0, 32'h0,    1));

    drive(v(0, 32'h0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0));
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

    // async reset mid-cycle while a taken jump update is presented
    @(negedge clk);
    drive(v(1, 32'h140, 1, 1, 32'h5000, 0, 32'h80, 0, 32'h0, 0));
    #1;
    chk("pre_reset_je", 100, 32'(bus.je), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_je", 101, 32'(bus.je), 32'h0);
    chk("async_jdest", 101, bus.jdest, 32'h0);
    chk("async_ghr", 101, 32'(bus.pred_ghr), 32'h0);
    @(posedge clk);
    #1;
    chk("held_je", 102, 32'(bus.je), 32'h0);
    chk("held_jdest", 102, bus.jdest, 32'h0);
    @(negedge clk);
    bus.upd_valid = 1'b0;
    rst_n = 1'b1;

    for (int i = 0; i < post.size(); i++) run_vec(post[i], 200 + i);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
